// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the FETCH/READ/EXECUTE/WRITE BACK pipeline.
// Optional macro PIPE_CTRL_FWD_EN: EXECUTE->READ forwarding, so source hazards track in-flight loads only.
module pipeline_ctrl #(
  parameter int NUM_REGS = 8,
  parameter int REG_BITS = 3,
  parameter int LOAD_LAT = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                dec_valid_i,
  input  logic [REG_BITS-1:0] dec_src1_i,
  input  logic                dec_src1_used_i,
  input  logic [REG_BITS-1:0] dec_src2_i,
  input  logic                dec_src2_used_i,
  input  logic [REG_BITS-1:0] dec_dest_i,
  input  logic                dec_wr_i,
  input  logic                dec_load_i,
  input  logic                dec_halt_i,
  input  logic                ex_jump_i,
  input  logic                wb_wen_i,
  input  logic [REG_BITS-1:0] wb_dest_i,
  output logic                stall_fetch_o,
  output logic                stall_read_o,
  output logic                bubble_ex_o,
  output logic                flush_o,
  output logic                halted_o,
  output logic [NUM_REGS-1:0] pending_o
);

  typedef enum logic [1:0] {S_RUN, S_LOAD_WAIT, S_DRAIN, S_HALT} state_t;

  localparam logic [2:0] LAT = 3'(LOAD_LAT);

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_cnt, w_cnt_nxt;
  logic [NUM_REGS-1:0] r_pending, w_pending_nxt;
  logic [NUM_REGS-1:0] w_set_mask, w_clr_mask, w_src_mask;
  logic                w_hazard, w_issue;
  logic                w_stall, w_bubble, w_flush, w_halted;

`ifdef PIPE_CTRL_FWD_EN
  logic [NUM_REGS-1:0] r_load_pending, w_load_pending_nxt;
  assign w_src_mask = r_load_pending;
`else
  assign w_src_mask = r_pending;
`endif

  // Sources check the (possibly load-only) mask; WAW always checks every in-flight writer.
  assign w_hazard = (dec_src1_used_i & w_src_mask[dec_src1_i])
                  | (dec_src2_used_i & w_src_mask[dec_src2_i])
                  | (dec_wr_i        & r_pending[dec_dest_i]);

  assign w_issue = dec_valid_i & ~w_hazard & ~ex_jump_i & (r_state == S_RUN);

  assign w_set_mask = (w_issue & dec_wr_i) ? (NUM_REGS'(1) << dec_dest_i) : '0;
  assign w_clr_mask = wb_wen_i ? (NUM_REGS'(1) << wb_dest_i) : '0;
  assign w_pending_nxt = (r_pending & ~w_clr_mask) | w_set_mask;

`ifdef PIPE_CTRL_FWD_EN
  assign w_load_pending_nxt = (r_load_pending & ~w_clr_mask)
                            | (dec_load_i ? w_set_mask : '0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_bubble    = 1'b0;
    w_flush     = 1'b0;
    w_halted    = 1'b0;
    case (r_state)
      S_RUN: begin
        w_flush = ex_jump_i;
        if (ex_jump_i) begin
          // The squashed READ instruction must not reach EXECUTE; FETCH loads the target.
          w_bubble = 1'b1;
        end else if (dec_valid_i && w_hazard) begin
          w_stall  = 1'b1;
          w_bubble = 1'b1;
        end
        if (w_issue) begin
          if (dec_load_i) begin
            w_state_nxt = S_LOAD_WAIT;
            w_cnt_nxt   = LAT;
          end else if (dec_halt_i) begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_LOAD_WAIT: begin
        w_stall  = 1'b1;
        w_bubble = 1'b1;
        w_flush  = ex_jump_i;
        if (r_cnt <= 3'd1) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      S_DRAIN: begin
        w_stall  = 1'b1;
        w_bubble = 1'b1;
        w_flush  = ex_jump_i;
        if (r_pending == '0) w_state_nxt = S_HALT;
      end
      S_HALT: begin
        w_stall  = 1'b1;
        w_bubble = 1'b1;
        w_halted = 1'b1;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_RUN;
      r_cnt     <= 3'd0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pending <= w_pending_nxt;
    end
  end

`ifdef PIPE_CTRL_FWD_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_load_pending <= '0;
    else        r_load_pending <= w_load_pending_nxt;
  end
`endif

  // Outputs are forced low while reset is asserted, independent of the clock.
  assign stall_fetch_o = w_stall  & rst_i;
  assign stall_read_o  = w_stall  & rst_i;
  assign bubble_ex_o   = w_bubble & rst_i;
  assign flush_o       = w_flush  & rst_i;
  assign halted_o      = w_halted & rst_i;
  assign pending_o     = r_pending;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: reset, RAW/WAW stalls, load wait, jump flush, scoreboard priority, HALT.
module tb_pipeline_ctrl;
  logic       clk = 1'b0;
  logic       rst_i;
  logic       dec_valid_i, dec_src1_used_i, dec_src2_used_i, dec_wr_i, dec_load_i, dec_halt_i;
  logic [2:0] dec_src1_i, dec_src2_i, dec_dest_i, wb_dest_i;
  logic       ex_jump_i, wb_wen_i;
  logic       stall_fetch_o, stall_read_o, bubble_ex_o, flush_o, halted_o;
  logic [7:0] pending_o;
  logic [4:0] ctl;
  int         tests = 0;
  int         fails = 0;

  localparam logic [4:0] NONE  = 5'b00000;
  localparam logic [4:0] STALL = 5'b11100;
  localparam logic [4:0] HALTD = 5'b11101;

  pipeline_ctrl #(.NUM_REGS(8), .REG_BITS(3), .LOAD_LAT(2)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .dec_valid_i(dec_valid_i), .dec_src1_i(dec_src1_i), .dec_src1_used_i(dec_src1_used_i),
    .dec_src2_i(dec_src2_i), .dec_src2_used_i(dec_src2_used_i), .dec_dest_i(dec_dest_i),
    .dec_wr_i(dec_wr_i), .dec_load_i(dec_load_i), .dec_halt_i(dec_halt_i),
    .ex_jump_i(ex_jump_i), .wb_wen_i(wb_wen_i), .wb_dest_i(wb_dest_i),
    .stall_fetch_o(stall_fetch_o), .stall_read_o(stall_read_o), .bubble_ex_o(bubble_ex_o),
    .flush_o(flush_o), .halted_o(halted_o), .pending_o(pending_o)
  );

  assign ctl = {stall_fetch_o, stall_read_o, bubble_ex_o, flush_o, halted_o};

  always #5 clk = ~clk;

  task automatic idle();
    dec_valid_i = 0; dec_src1_used_i = 0; dec_src2_used_i = 0; dec_wr_i = 0;
    dec_load_i = 0; dec_halt_i = 0; ex_jump_i = 0; wb_wen_i = 0;
    dec_src1_i = 0; dec_src2_i = 0; dec_dest_i = 0; wb_dest_i = 0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    rst_i = 0; idle(); #1;
    tests++; if (ctl !== NONE) begin fails++; $display("FAIL reset_ctl: got %b want %b", ctl, NONE); end
    tests++; if (pending_o !== 8'h00) begin fails++; $display("FAIL reset_pend: got %h want 00", pending_o); end
    @(negedge clk); rst_i = 1;
    next_cycle(); dec_valid_i = 1; dec_wr_i = 1; dec_dest_i = 3; #1;
    tests++; if (ctl !== NONE) begin fails++; $display("FAIL rst_issue_r3: got %b want %b", ctl, NONE); end
    next_cycle(); dec_valid_i = 1; dec_src1_used_i = 1; dec_src1_i = 3; #1;
    tests++; if (ctl !== STALL) begin fails++; $display("FAIL rst_midstall: got %b want %b", ctl, STALL); end
    #2 rst_i = 0; #1;
    tests++; if (ctl !== NONE) begin fails++; $display("FAIL rst_async_ctl: got %b want %b", ctl, NONE); end
    tests++; if (pending_o !== 8'h00) begin fails++; $display("FAIL rst_async_pend: got %h want 00", pending_o); end
    @(negedge clk); rst_i = 1; idle(); #1;
    tests++; if (pending_o !== 8'h00) begin fails++; $display("FAIL rst_release_pend: got %h want 00", pending_o); end
  endtask

  task automatic test_raw();
    next_cycle(); dec_valid_i = 1; dec_wr_i = 1; dec_dest_i = 1; #1;
    tests++; if (ctl !== NONE) begin fails++; $display("FAIL raw_add_r1: got %b want %b", ctl, NONE); end
`ifdef PIPE_CTRL_FWD_EN
    next_cycle(); dec_valid_i = 1; dec_src1_used_i = 1; dec_src1_i = 1; dec_wr_i = 1; dec_dest_i = 5; #1;
    tests++; if (ctl !== NONE) begin fails++; $display("FAIL raw_fwd_nostall: got %b want %b", ctl, NONE); end
    next_cycle(); wb_wen_i = 1; wb_dest_i = 1; #1;
    tests++; if (pending_o !== 8'h22) begin fails++; $display("FAIL raw_fwd_pend: got %h want 22", pending_o); end
    next_cycle(); wb_wen_i = 1; wb_dest_i = 5;
`else
    for (int i = 0; i < 3; i++) begin
      next_cycle(); dec_valid_i = 1; dec_src1_used_i = 1; dec_src1_i = 1; dec_wr_i = 1; dec_dest_i = 5;
      if (i == 2) begin wb_wen_i = 1; wb_dest_i = 1; end
      #1;
      tests++; if (ctl !== STALL) begin fails++; $display("FAIL raw_stall_%0d: got %b want %b", i, ctl, STALL); end
    end
    tests++; if (pending_o !== 8'h02) begin fails++; $display("FAIL raw_pend_r1: got %h want 02", pending_o); end
    next_cycle(); dec_valid_i = 1; dec_src1_used_i = 1; dec_src1_i = 1; dec_wr_i = 1; dec_dest_i = 5; #1;
    tests++; if (ctl !== NONE) begin fails++; $display("FAIL raw_issue_after_wb: got %b want %b", ctl, NONE); end
    next_cycle(); wb_wen_i = 1; wb_dest_i = 5; #1;
    tests++; if (pending_o !== 8'h20) begin fails++; $display("FAIL raw_pend_r5: got %h want 20", pending_o); end
`endif
    next_cycle(); #1;
    tests++; if (pending_o !== 8'h00) begin fails++; $display("FAIL raw_pend_clear: got %h want 00", pending_o); end
  endtask

  task automatic test_load();
    next_cycle(); dec_valid_i = 1; dec_load_i = 1; dec_wr_i = 1; dec_dest_i = 2; #1;
    tests++; if (ctl !== NONE) begin fails++; $display("FAIL load_issue: got %b want %b", ctl, NONE); end
    for (int i = 0; i < 2; i++) begin
      next_cycle(); #1;
      tests++; if (ctl !== STALL) begin fails++; $display("FAIL load_wait_%0d: got %b want %b", i, ctl, STALL); end
    end
    next_cycle(); #1;
    tests++; if (ctl !== NONE) begin fails++; $display("FAIL load_back_to_run: got %b want %b", ctl, NONE); end
    tests++; if (pending_o !== 8'h04) begin fails++; $display("FAIL load_pend_r2: got %h want 04", pending_o); end
    for (int i = 0; i < 2; i++) begin
      next_cycle(); dec_valid_i = 1; dec_src2_used_i = 1; dec_src2_i = 2; dec_wr_i = 1; dec_dest_i = 6;
      if (i == 1) begin wb_wen_i = 1; wb_dest_i = 2; end
      #1;
      tests++; if (ctl !== STALL) begin fails++; $display("FAIL load_use_%0d: got %b want %b", i, ctl, STALL); end
    end
    next_cycle(); dec_valid_i = 1; dec_src2_used_i = 1; dec_src2_i = 2; dec_wr_i = 1; dec_dest_i = 6; #1;
    tests++; if (ctl !== NONE) begin fails++; $display("FAIL load_use_issue: got %b want %b", ctl, NONE); end
    next_cycle(); wb_wen_i = 1; wb_dest_i = 6; #1;
    tests++; if (pending_o !== 8'h40) begin fails++; $display("FAIL load_pend_r6: got %h want 40", pending_o); end
    next_cycle();
  endtask

  task automatic test_jump();
    next_cycle(); dec_valid_i = 1; dec_wr_i = 1; dec_dest_i = 3;
    next_cycle(); dec_valid_i = 1; dec_src1_used_i = 1; dec_src1_i = 3; dec_wr_i = 1; dec_dest_i = 6; ex_jump_i = 1; #1;
    tests++; if ({ctl[4:3], ctl[1]} !== 3'b001) begin fails++; $display("FAIL jump_flush: sf/sr/fl got %b want 001", {ctl[4:3], ctl[1]}); end
    next_cycle(); #1;
    tests++; if (pending_o !== 8'h08) begin fails++; $display("FAIL jump_pend: got %h want 08", pending_o); end
    next_cycle(); dec_valid_i = 1; dec_load_i = 1; dec_wr_i = 1; dec_dest_i = 7; #1;
    tests++; if (ctl !== NONE) begin fails++; $display("FAIL jump_load_issue: got %b want %b", ctl, NONE); end
    next_cycle(); dec_valid_i = 1; dec_wr_i = 1; dec_dest_i = 4; ex_jump_i = 1; #1;
    tests++; if (ctl !== 5'b11110) begin fails++; $display("FAIL jump_in_loadwait: got %b want 11110", ctl); end
    next_cycle(); #1;
    tests++; if (ctl !== STALL) begin fails++; $display("FAIL jump_loadwait_hold: got %b want %b", ctl, STALL); end
    next_cycle(); #1;
    tests++; if (ctl !== NONE) begin fails++; $display("FAIL jump_loadwait_end: got %b want %b", ctl, NONE); end
    tests++; if (pending_o !== 8'h88) begin fails++; $display("FAIL jump_squash_pend: got %h want 88", pending_o); end
    next_cycle(); wb_wen_i = 1; wb_dest_i = 3;
    next_cycle(); wb_wen_i = 1; wb_dest_i = 7;
    next_cycle(); #1;
    tests++; if (pending_o !== 8'h00) begin fails++; $display("FAIL jump_pend_clear: got %h want 00", pending_o); end
  endtask

  task automatic test_same_cycle();
    next_cycle(); dec_valid_i = 1; dec_wr_i = 1; dec_dest_i = 4; wb_wen_i = 1; wb_dest_i = 4; #1;
    tests++; if (ctl !== NONE) begin fails++; $display("FAIL same_issue: got %b want %b", ctl, NONE); end
    next_cycle(); wb_wen_i = 1; wb_dest_i = 0; #1;
    tests++; if (pending_o !== 8'h10) begin fails++; $display("FAIL same_set_wins: got %h want 10", pending_o); end
    next_cycle(); dec_valid_i = 1; dec_wr_i = 1; dec_dest_i = 4; #1;
    tests++; if (pending_o !== 8'h10) begin fails++; $display("FAIL wb_nonpending: got %h want 10", pending_o); end
    tests++; if (ctl !== STALL) begin fails++; $display("FAIL waw_stall: got %b want %b", ctl, STALL); end
    next_cycle(); wb_wen_i = 1; wb_dest_i = 4;
    next_cycle(); #1;
    tests++; if (pending_o !== 8'h00) begin fails++; $display("FAIL same_pend_clear: got %h want 00", pending_o); end
  endtask

  task automatic test_halt();
    next_cycle(); dec_valid_i = 1; dec_wr_i = 1; dec_dest_i = 1;
    next_cycle(); dec_valid_i = 1; dec_wr_i = 1; dec_dest_i = 2;
    next_cycle(); dec_valid_i = 1; dec_halt_i = 1; #1;
    tests++; if (ctl !== NONE) begin fails++; $display("FAIL halt_issue: got %b want %b", ctl, NONE); end
    tests++; if (pending_o !== 8'h06) begin fails++; $display("FAIL halt_pend: got %h want 06", pending_o); end
    next_cycle(); #1;
    tests++; if (ctl !== STALL) begin fails++; $display("FAIL drain_0: got %b want %b", ctl, STALL); end
    next_cycle(); wb_wen_i = 1; wb_dest_i = 1; #1;
    tests++; if (ctl !== STALL) begin fails++; $display("FAIL drain_1: got %b want %b", ctl, STALL); end
    next_cycle(); wb_wen_i = 1; wb_dest_i = 2; #1;
    tests++; if (ctl !== STALL) begin fails++; $display("FAIL drain_2: got %b want %b", ctl, STALL); end
    next_cycle(); #1;
    tests++; if (ctl !== STALL || pending_o !== 8'h00) begin fails++; $display("FAIL drain_last: got %b/%h want %b/00", ctl, pending_o, STALL); end
    next_cycle(); dec_valid_i = 1; dec_wr_i = 1; ex_jump_i = 1; #1;
    tests++; if (ctl !== HALTD) begin fails++; $display("FAIL halted: got %b want %b", ctl, HALTD); end
    next_cycle(); #1;
    tests++; if (ctl !== HALTD || pending_o !== 8'h00) begin fails++; $display("FAIL halted_hold: got %b/%h want %b/00", ctl, pending_o, HALTD); end
    #2 rst_i = 0; #1;
    tests++; if (ctl !== NONE) begin fails++; $display("FAIL halt_reset: got %b want %b", ctl, NONE); end
    @(negedge clk); rst_i = 1; idle();
    next_cycle(); #1;
    tests++; if (ctl !== NONE) begin fails++; $display("FAIL halt_exit: got %b want %b", ctl, NONE); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_load();
    test_jump();
    test_same_cycle();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end
endmodule
